pe_result_drain: RTL and testbench

//  Downstream of the PE controller. On its done pulse, reads the VECTOR_SIZE result words the controller

---
 rtl/pe_result_drain.sv | 150 +++++++++++++++
 tb/tb_pe_result_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_drain.sv
// Drains VECTOR_SIZE result words from the shared result BRAM after a PE done pulse
// and streams them out in index order through a small credit-managed output FIFO.
module pe_result_drain #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          VECTOR_SIZE = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          FIFO_DEPTH  = 4,
  localparam int         IDX_W       = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  pe_done,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  overrun,
  output logic [1:0]            dbg_state,
  output logic [31:0]           BRAM_ADDR,
  output logic                  BRAM_EN,
  output logic [3:0]            BRAM_WE,
  output logic                  BRAM_CLK,
  input  logic [31:0]           BRAM_RDDATA,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [IDX_W-1:0]      m_tindex,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]      addr_q, addr_d;
  logic             inflight_q, inflight_d;
  logic [IDX_W-1:0] infl_idx_q, infl_idx_d;
  logic             overrun_q, overrun_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0]      mem_idx  [FIFO_DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] issue_addr;

  // A read is only issued when the FIFO is guaranteed a free slot for its return data,
  // counting the read still in flight, so pushes can never be refused.
  assign issue      = (state_q == S_READ) &&
                      ((occ_q + OCC_W'(inflight_q)) < OCC_W'(FIFO_DEPTH));
  assign issue_addr = BASE_ADDR + (32'(rd_idx_q) << 2);
  assign push       = inflight_q;
  // Stream handshake: a word transfers on every clock where m_tvalid & m_tready; while
  // m_tvalid is high and m_tready low, data/index/last hold and m_tvalid stays high.
  assign pop        = m_tvalid && m_tready;

  assign busy       = (state_q != S_IDLE);
  assign drain_done = (state_q == S_FLUSH) && (occ_q == '0) && !inflight_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

  assign BRAM_EN    = issue;
  assign BRAM_ADDR  = issue ? issue_addr : addr_q;
  assign BRAM_WE    = 4'h0;
  assign BRAM_CLK   = aclk;

  assign m_tvalid   = (occ_q != '0);
  assign m_tdata    = m_tvalid ? mem_data[rd_ptr_q] : '0;
  assign m_tindex   = m_tvalid ? mem_idx[rd_ptr_q] : '0;
  assign m_tlast    = m_tvalid && (mem_idx[rd_ptr_q] == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    addr_d     = addr_q;
    inflight_d = issue;
    infl_idx_d = issue ? rd_idx_q : infl_idx_q;
    overrun_d  = overrun_q | (pe_done & (state_q != S_IDLE));
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);

    if (issue) begin
      rd_idx_d = rd_idx_q + IDX_W'(1);
      addr_d   = issue_addr;
    end

    case (state_q)
      S_IDLE: begin
        rd_idx_d = '0;
        if (pe_done) state_d = S_READ;
      end
      S_READ: begin
        if (issue && (rd_idx_q == LAST_IDX)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (drain_done) begin
          state_d  = S_IDLE;
          rd_idx_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      addr_q     <= BASE_ADDR;
      inflight_q <= 1'b0;
      infl_idx_q <= '0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      infl_idx_q <= infl_idx_d;
      overrun_q  <= overrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy, which is reset.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= DATA_WIDTH'(BRAM_RDDATA);
      mem_idx[wr_ptr_q]  <= infl_idx_q;
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: BRAM model, per-cycle output checks, expected-word queue.
module tb_pe_result_drain;

  localparam int DW = 32;
  localparam int VS = 64;
  localparam int FD = 4;
  localparam int IW = 6;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          pe_done = 1'b0;
  logic          m_tready = 1'b0;
  logic          busy, drain_done, overrun;
  logic [1:0]    dbg_state;
  logic [31:0]   BRAM_ADDR;
  logic          BRAM_EN;
  logic [3:0]    BRAM_WE;
  logic          BRAM_CLK;
  logic [31:0]   BRAM_RDDATA = 32'h0;
  logic [DW-1:0] m_tdata;
  logic [IW-1:0] m_tindex;
  logic          m_tvalid, m_tlast;

  pe_result_drain dut (
    .aclk(aclk), .aresetn(aresetn), .pe_done(pe_done), .busy(busy),
    .drain_done(drain_done), .overrun(overrun), .dbg_state(dbg_state),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_CLK(BRAM_CLK),
    .BRAM_RDDATA(BRAM_RDDATA), .m_tdata(m_tdata), .m_tindex(m_tindex),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // Clock and BRAM model (one-cycle read latency)
  always #5 aclk = ~aclk;

  logic [31:0] bram [VS];
  always @(posedge aclk) begin
    if (BRAM_EN) BRAM_RDDATA <= bram[BRAM_ADDR[IW+1:2]];
  end

  int checks = 0;
  int errors = 0;
  int cyc, occ_m, exp_rd, max_occ;
  int hs_count, done_count, done_cyc, first_valid_cyc, last_hs_cyc;
  bit inflight_m, prev_en, prev_hs, prev_stall;
  logic [38:0] prev_word;
  logic [38:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ_m = 0; inflight_m = 0; prev_en = 0; prev_hs = 0; prev_stall = 0;
    exp_rd = 0; max_occ = 0; exp_q.delete();
    hs_count = 0; done_count = 0; done_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1;
    cyc = 0;
  endtask

  task automatic load_exp();
    for (int i = 0; i < VS; i++) begin
      logic [IW-1:0] idx;
      idx = IW'(i);
      exp_q.push_back({(i == VS - 1), idx, 32'h1000_0000 + 32'(i)});
    end
  endtask

  // One clock: drive inputs at the falling edge, then check outputs 1 ns later.
  task automatic step(input logic pe, input logic rdy);
    logic [38:0] w;
    logic [38:0] e;
    @(negedge aclk);
    pe_done = pe;
    m_tready = rdy;
    #1;
    occ_m = occ_m + int'(inflight_m) - int'(prev_hs);
    inflight_m = prev_en;
    w = {m_tlast, m_tindex, m_tdata};
    chk("tvalid_vs_occupancy", 64'(m_tvalid), 64'(occ_m != 0));
    if (BRAM_EN) begin
      chk("bram_credit", 64'((occ_m + int'(inflight_m)) < FD), 64'(1));
      chk("bram_addr", 64'(BRAM_ADDR), 64'(32'((exp_rd % VS) * 4)));
      exp_rd++;
    end
    if (prev_stall) chk("stall_stable", 64'(w), 64'(prev_word));
    if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_tvalid && m_tready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_word: observed=0x%0h expected=none", w);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream_word", 64'(w), 64'(e));
      end
      hs_count++;
      last_hs_cyc = cyc;
    end
    if (drain_done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (occ_m > max_occ) max_occ = occ_m;
    prev_en = BRAM_EN;
    prev_hs = m_tvalid & m_tready;
    prev_stall = m_tvalid & ~m_tready;
    prev_word = w;
    cyc++;
  endtask

  // mode 0: ready held high, mode 1: ready random 50%
  task automatic finish_drain(input int mode, input int pe_at, input int want_done);
    bit fin;
    fin = 0;
    for (int k = 0; k < 600; k++) begin
      if (done_count >= want_done && !busy) begin
        fin = 1;
        break;
      end
      step(cyc == pe_at, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL drain_timeout: observed=%0d drains expected=%0d", done_count, want_done);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_drain_done"}, 64'(drain_done), 64'(0));
    chk({tag, "_overrun"}, 64'(overrun), 64'(0));
    chk({tag, "_bram_en"}, 64'(BRAM_EN), 64'(0));
    chk({tag, "_bram_addr"}, 64'(BRAM_ADDR), 64'(0));
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, "_tlast"}, 64'(m_tlast), 64'(0));
    chk({tag, "_tdata"}, 64'(m_tdata), 64'(0));
    chk({tag, "_tindex"}, 64'(m_tindex), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < VS; i++) bram[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    chk_reset_outputs("reset");
    chk("bram_we", 64'(BRAM_WE), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) step(1'b0, 1'b1);

    // 1: full-rate drain
    model_reset(); load_exp();
    step(1'b1, 1'b1);
    finish_drain(0, -1, 1);
    chk("t1_first_valid_cyc", 64'(first_valid_cyc), 64'(3));
    chk("t1_words", 64'(hs_count), 64'(64));
    chk("t1_last_hs_cyc", 64'(last_hs_cyc), 64'(66));
    chk("t1_done_count", 64'(done_count), 64'(1));
    chk("t1_done_cyc", 64'(done_cyc), 64'(67));
    chk("t1_reads", 64'(exp_rd), 64'(64));
    chk("t1_busy_after", 64'(busy), 64'(0));
    chk("t1_overrun", 64'(overrun), 64'(0));

    // 2: random backpressure
    model_reset(); load_exp();
    step(1'b1, 1'($urandom_range(0, 1)));
    finish_drain(1, -1, 1);
    chk("t2_words", 64'(hs_count), 64'(64));
    chk("t2_done_count", 64'(done_count), 64'(1));
    chk("t2_max_occ_ok", 64'(max_occ <= FD), 64'(1));
    chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // 3: consumer stalled for 20 cycles after start
    model_reset(); load_exp();
    step(1'b1, 1'b0);
    repeat (19) step(1'b0, 1'b0);
    chk("t3_reads_during_stall", 64'(exp_rd), 64'(FD));
    chk("t3_words_during_stall", 64'(hs_count), 64'(0));
    chk("t3_busy", 64'(busy), 64'(1));
    finish_drain(0, -1, 1);
    chk("t3_words", 64'(hs_count), 64'(64));
    chk("t3_no_gaps_last_hs", 64'(last_hs_cyc), 64'(20 + 63));
    chk("t3_done_count", 64'(done_count), 64'(1));

    // 4: second pe_done mid-drain
    model_reset(); load_exp();
    step(1'b1, 1'b1);
    finish_drain(0, 10, 1);
    chk("t4_overrun", 64'(overrun), 64'(1));
    chk("t4_words", 64'(hs_count), 64'(64));
    chk("t4_done_count", 64'(done_count), 64'(1));
    chk("t4_done_cyc", 64'(done_cyc), 64'(67));
    repeat (5) step(1'b0, 1'b1);
    chk("t4_overrun_sticky", 64'(overrun), 64'(1));
    chk("t4_no_extra_done", 64'(done_count), 64'(1));

    // 5: asynchronous reset in the middle of a drain
    model_reset(); load_exp();
    step(1'b1, 1'b1);
    for (int k = 0; k < 200 && hs_count < 30; k++) step(1'b0, 1'b1);
    chk("t5_words_before_reset", 64'(hs_count), 64'(30));
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("t5_reset");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    model_reset(); load_exp();
    step(1'b0, 1'b1);
    model_reset(); load_exp();
    step(1'b1, 1'b1);
    finish_drain(0, -1, 1);
    chk("t5_first_valid_cyc", 64'(first_valid_cyc), 64'(3));
    chk("t5_words", 64'(hs_count), 64'(64));
    chk("t5_done_cyc", 64'(done_cyc), 64'(67));

    // 6: back-to-back drains, second pe_done the cycle after drain_done
    model_reset(); load_exp(); load_exp();
    step(1'b1, 1'b1);
    finish_drain(0, 68, 2);
    chk("t6_words", 64'(hs_count), 64'(128));
    chk("t6_done_count", 64'(done_count), 64'(2));
    chk("t6_second_done_cyc", 64'(done_cyc), 64'(68 + 67));
    chk("t6_overrun", 64'(overrun), 64'(0));
    chk("t6_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
